// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
// Folds a stream of per-bit {lt,gt,eq} codes, MSB first, into a word-level
// magnitude result. The first differing bit decides; later bits are only
// counted. Non-one-hot bit codes raise err for that comparison.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic lt_in,
    input  logic gt_in,
    input  logic eq_in,
    output logic busy,
    output logic result_valid,
    output logic lt,
    output logic gt,
    output logic eq,
    output logic err
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        ACC_EQ,
        ACC_LT,
        ACC_GT
    } acc_t;

    state_t        r_state;
    acc_t          r_acc;
    logic          r_decided;
    logic          r_err_acc;
    logic [CW-1:0] r_cnt;

    acc_t          w_next_acc;
    logic          w_next_decided;
    logic          w_next_err;
    logic          w_last;

    // Fold the current bit code into the running decision and error flag
    always_comb begin
        w_next_acc     = r_acc;
        w_next_decided = r_decided;
        w_next_err     = r_err_acc;
        w_last         = (r_cnt == LAST);
        case ({lt_in, gt_in, eq_in})
            3'b100: begin
                if (!r_decided) begin
                    w_next_acc     = ACC_LT;
                    w_next_decided = 1'b1;
                end
            end
            3'b010: begin
                if (!r_decided) begin
                    w_next_acc     = ACC_GT;
                    w_next_decided = 1'b1;
                end
            end
            3'b001:  ;
            default: w_next_err = 1'b1;
        endcase
    end

    // Control FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_acc        <= ACC_EQ;
            r_decided    <= 1'b0;
            r_err_acc    <= 1'b0;
            r_cnt        <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            lt           <= 1'b0;
            gt           <= 1'b0;
            eq           <= 1'b0;
            err          <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_COMPARE;
                        r_acc     <= ACC_EQ;
                        r_decided <= 1'b0;
                        r_err_acc <= 1'b0;
                        r_cnt     <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_COMPARE: begin
                    if (start) begin
                        // Restart: bit_valid in this cycle is discarded
                        r_acc     <= ACC_EQ;
                        r_decided <= 1'b0;
                        r_err_acc <= 1'b0;
                        r_cnt     <= '0;
                    end else if (bit_valid) begin
                        r_acc     <= w_next_acc;
                        r_decided <= w_next_decided;
                        r_err_acc <= w_next_err;
                        r_cnt     <= r_cnt + CW'(1);
                        if (w_last) begin
                            // Results load with the strobe so both appear in DONE
                            r_state      <= S_DONE;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                            lt           <= (w_next_acc == ACC_LT);
                            gt           <= (w_next_acc == ACC_GT);
                            eq           <= (w_next_acc == ACC_EQ);
                            err          <= w_next_err;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        r_state   <= S_COMPARE;
                        r_acc     <= ACC_EQ;
                        r_decided <= 1'b0;
                        r_err_acc <= 1'b0;
                        r_cnt     <= '0;
                        busy      <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Testbench for serial_magnitude_comparator (WIDTH=8 and WIDTH=1 instances).
module tb_serial_magnitude_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, bit_valid, lt_in, gt_in, eq_in;
    logic busy, result_valid, lt, gt, eq, err;
    logic s1_start, s1_bit_valid, s1_lt_in, s1_gt_in, s1_eq_in;
    logic s1_busy, s1_result_valid, s1_lt, s1_gt, s1_eq, s1_err;

    int checks = 0;
    int errors = 0;
    logic [3:0] prev;

    serial_magnitude_comparator #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
        .lt_in(lt_in), .gt_in(gt_in), .eq_in(eq_in),
        .busy(busy), .result_valid(result_valid),
        .lt(lt), .gt(gt), .eq(eq), .err(err)
    );

    serial_magnitude_comparator #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .bit_valid(s1_bit_valid),
        .lt_in(s1_lt_in), .gt_in(s1_gt_in), .eq_in(s1_eq_in),
        .busy(s1_busy), .result_valid(s1_result_valid),
        .lt(s1_lt), .gt(s1_gt), .eq(s1_eq), .err(s1_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-bit codes {lt,gt,eq} for operands a and b; bit i lives at [3*i +: 3]
    function automatic logic [23:0] make_codes(input logic [7:0] a, input logic [7:0] b);
        logic [23:0] m;
        m = '0;
        for (int i = 0; i < 8; i++)
            m[3*i +: 3] = (a[i] < b[i]) ? 3'b100 : ((a[i] > b[i]) ? 3'b010 : 3'b001);
        return m;
    endfunction

    // Word result {lt,gt,eq,err} for a possibly corrupted code stream:
    // the most significant valid differing code wins, any invalid code sets err
    function automatic logic [3:0] scan_ref(input logic [23:0] codes);
        logic [2:0] res;
        logic       e;
        logic       found;
        logic [2:0] c;
        res = 3'b001;
        e = 1'b0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            c = codes[3*i +: 3];
            if (c != 3'b100 && c != 3'b010 && c != 3'b001) e = 1'b1;
            else if (!found && c != 3'b001) begin
                res = c;
                found = 1'b1;
            end
        end
        return {res, e};
    endfunction

    function automatic logic [3:0] arith_ref(input logic [7:0] a, input logic [7:0] b);
        return {a < b, a > b, a == b, 1'b0};
    endfunction

    // Start a comparison, stream 8 codes MSB first with `stalls` idle cycles, check result
    task automatic do_cmp8(input logic [23:0] codes, input logic [3:0] exp,
                           input int stalls, input string tag);
        int n_acc;
        int cycles;
        int left;
        n_acc = 0;
        cycles = 0;
        left = stalls;
        start = 1'b1;
        bit_valid = 1'b1;
        {lt_in, gt_in, eq_in} = 3'b010;
        tick();
        start = 1'b0;
        bit_valid = 1'b0;
        chk({tag, ":busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, ":rv_after_start"}, 32'(result_valid), 32'd0);
        chk({tag, ":held_after_start"}, 32'({lt, gt, eq, err}), 32'(prev));
        while (n_acc < 8) begin
            if (left > 0 && (n_acc == 7 || $urandom_range(0, 1) == 1)) begin
                bit_valid = 1'b0;
                {lt_in, gt_in, eq_in} = 3'b100;
                left--;
            end else begin
                bit_valid = 1'b1;
                {lt_in, gt_in, eq_in} = codes[3*(7-n_acc) +: 3];
                n_acc++;
            end
            tick();
            cycles++;
            if (n_acc < 8) begin
                chk({tag, ":busy_mid"}, 32'(busy), 32'd1);
                chk({tag, ":rv_mid"}, 32'(result_valid), 32'd0);
            end
        end
        bit_valid = 1'b0;
        chk({tag, ":rv_done"}, 32'(result_valid), 32'd1);
        chk({tag, ":busy_done"}, 32'(busy), 32'd0);
        chk({tag, ":latency"}, 32'(cycles), 32'(8 + stalls));
        chk({tag, ":result"}, 32'({lt, gt, eq, err}), 32'(exp));
        prev = exp;
        tick();
        chk({tag, ":rv_one_cycle"}, 32'(result_valid), 32'd0);
        chk({tag, ":held_after_done"}, 32'({lt, gt, eq, err}), 32'(prev));
    endtask

    logic [23:0] codes;
    logic [7:0]  ra, rb;
    logic [2:0]  bad_tab [5];

    initial begin
        bad_tab[0] = 3'b000; bad_tab[1] = 3'b011; bad_tab[2] = 3'b101;
        bad_tab[3] = 3'b110; bad_tab[4] = 3'b111;
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0;
        lt_in = 1'b0; gt_in = 1'b0; eq_in = 1'b0;
        s1_start = 1'b0; s1_bit_valid = 1'b0;
        s1_lt_in = 1'b0; s1_gt_in = 1'b0; s1_eq_in = 1'b0;
        prev = '0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("reset_w8", 32'({busy, result_valid, lt, gt, eq, err}), 32'd0);
        chk("reset_w1", 32'({s1_busy, s1_result_valid, s1_lt, s1_gt, s1_eq, s1_err}), 32'd0);
        rst = 1'b0;
        tick();

        // Basic directed comparisons
        do_cmp8(make_codes(8'hA5, 8'hA3), 4'b0100, 0, "a5_a3");
        do_cmp8(make_codes(8'h3C, 8'h3C), 4'b0010, 0, "eq_3c");
        do_cmp8(make_codes(8'h00, 8'h80), 4'b1000, 0, "lt_msb");
        do_cmp8(make_codes(8'hA5, 8'hA3), 4'b0100, 3, "a5_a3_stall3");

        // Invalid code at bit 4, then a clean comparison clears err
        codes = make_codes(8'h55, 8'h55);
        codes[12 +: 3] = 3'b110;
        do_cmp8(codes, 4'b0011, 0, "bad_bit4");
        do_cmp8(make_codes(8'h3C, 8'h3C), 4'b0010, 0, "clean_after_bad");

        // Restart after 5 accepted bits: a fresh 8-bit comparison follows
        codes = make_codes(8'hFF, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            {lt_in, gt_in, eq_in} = codes[3*(7-i) +: 3];
            tick();
            chk("restart_pre_rv", 32'(result_valid), 32'd0);
        end
        bit_valid = 1'b0;
        do_cmp8(make_codes(8'hA3, 8'hA5), 4'b1000, 0, "restart");

        // Reset after 3 bits: no strobe, all outputs cleared
        codes = make_codes(8'h80, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1;
            {lt_in, gt_in, eq_in} = codes[3*(7-i) +: 3];
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bit_valid = 1'b0;
        chk("midreset_outputs", 32'({busy, result_valid, lt, gt, eq, err}), 32'd0);
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        chk("midreset_idle", 32'({busy, result_valid}), 32'd0);
        prev = '0;

        // Randomized comparisons, some with a corrupted bit code
        for (int n = 0; n < 20; n++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 9) < 3) ? ra : 8'($urandom);
            codes = make_codes(ra, rb);
            if ($urandom_range(0, 3) == 0) begin
                codes[3*$urandom_range(0, 7) +: 3] = bad_tab[$urandom_range(0, 4)];
                do_cmp8(codes, scan_ref(codes), int'($urandom_range(0, 3)), "rand_bad");
            end else begin
                do_cmp8(codes, arith_ref(ra, rb), int'($urandom_range(0, 3)), "rand_clean");
            end
        end

        // WIDTH=1 instance: one bit per comparison, start held in DONE
        s1_start = 1'b1;
        tick();
        s1_start = 1'b0;
        chk("w1_busy", 32'(s1_busy), 32'd1);
        s1_bit_valid = 1'b1;
        {s1_lt_in, s1_gt_in, s1_eq_in} = 3'b010;
        tick();
        s1_bit_valid = 1'b0;
        chk("w1_rv", 32'({s1_result_valid, s1_busy}), 32'b10);
        chk("w1_gt", 32'({s1_lt, s1_gt, s1_eq, s1_err}), 32'b0100);
        s1_start = 1'b1;
        tick();
        s1_start = 1'b0;
        chk("w1_restart_from_done", 32'({s1_result_valid, s1_busy}), 32'b01);
        s1_bit_valid = 1'b1;
        {s1_lt_in, s1_gt_in, s1_eq_in} = 3'b100;
        tick();
        s1_bit_valid = 1'b0;
        chk("w1_rv2", 32'(s1_result_valid), 32'd1);
        chk("w1_lt", 32'({s1_lt, s1_gt, s1_eq, s1_err}), 32'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
